serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. A single full-adder cell and a
//               carry flip-flop process the operands LSB-first, one bit per
//               clock. Operands are accepted in parallel on a valid/ready
//               handshake, and the parallel result is returned on a second
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH  operand/sum width in bits, legal range 2..64
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operands and c_in valid
//               in_ready   block can accept operands (IDLE only)
//               a, b       operands
//               c_in       carry into bit 0
//               sub        (SERIAL_ADDER_SUB_EN only) 1 = compute a-b
//               out_valid  sum/c_out valid
//               out_ready  consumer accepts the result
//               sum        low WIDTH bits of a+b+c_in
//               c_out      carry out of bit WIDTH-1
//               busy       high while bits are being processed
// Options     : `define SERIAL_ADDER_SUB_EN adds the sub port; with
//               sub=1 the block loads ~b and forces the initial carry to 1,
//               so c_out=1 means no borrow.
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 result bits need storing: the final bit comes straight
  // from the cell on the last edge.
  logic [WIDTH-2:0] sum_sr;
  logic             carry_ff;
  logic [CW-1:0]    count;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_cat;

  // Full-adder cell fed with the current bit triple.
  assign fa_s  = a_sr[0] ^ b_sr[0] ^ carry_ff;
  assign fa_co = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_ff) | (b_sr[0] & carry_ff);

  // New sum bit enters at the MSB; after WIDTH shifts the whole word is aligned.
  assign sum_cat = {fa_s, sum_sr};

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_ff  <= 1'b0;
      count     <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sr     <= sub ? ~b : b;
            carry_ff <= sub ? 1'b1 : c_in;
`else
            b_sr     <= b;
            carry_ff <= c_in;
`endif
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sr   <= sum_cat[WIDTH-1:1];
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          carry_ff <= fa_co;
          count    <= count + 1'b1;
          if (count == LAST) begin
            sum       <= sum_cat;
            c_out     <= fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  int tests;
  int fails;
  int lat;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operation, accepts it, scrambles the inputs, and counts the
  // edges after the accept edge until out_valid rises (bounded).
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tc, input logic ts, output int latency);
    chk({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    latency = 0;
    while (!out_valid && latency < 20) begin
      step();
      latency++;
    end
    sub = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    #12;
    // Reset values
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    rst_n = 1'b1;
    step();

    // 0x0F + 0x01 = 0x10, latency 8, in_ready back one edge later
    do_op("op1", 8'h0F, 8'h01, 1'b0, 1'b0, lat);
    chk("op1_latency", 64'(lat), 64'd8);
    chk("op1_sum", 64'(sum), 64'h10);
    chk("op1_c_out", 64'(c_out), 64'd0);
    chk("op1_in_ready_done", 64'(in_ready), 64'd0);
    step();
    chk("op1_out_valid_fall", 64'(out_valid), 64'd0);
    chk("op1_in_ready_back", 64'(in_ready), 64'd1);

    // 0xFF + 0x01 = 0x100
    do_op("op2", 8'hFF, 8'h01, 1'b0, 1'b0, lat);
    chk("op2_latency", 64'(lat), 64'd8);
    chk("op2_sum", 64'(sum), 64'h00);
    chk("op2_c_out", 64'(c_out), 64'd1);
    step();

    // 0xFF + 0xFF + 1 = 0x1FF
    do_op("op3", 8'hFF, 8'hFF, 1'b1, 1'b0, lat);
    chk("op3_sum", 64'(sum), 64'hFF);
    chk("op3_c_out", 64'(c_out), 64'd1);
    step();

    // Backpressure: 0x12 + 0x34 = 0x46 held for 5 cycles
    out_ready = 1'b0;
    do_op("bp", 8'h12, 8'h34, 1'b0, 1'b0, lat);
    chk("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_sum", 64'(sum), 64'h46);
      chk("bp_hold_c_out", 64'(c_out), 64'd0);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_out_valid_fall", 64'(out_valid), 64'd0);
    chk("bp_sum_retained", 64'(sum), 64'h46);

    // in_valid held high during RUN with new operands: ignored until IDLE
    do_op("iv1", 8'h21, 8'h10, 1'b0, 1'b0, lat);
    // do_op scrambled inputs after accept; now hold a second request during RUN
    // (already at DONE here, so re-run with the request raised right after accept)
    step();
    chk("iv_pre_in_ready", 64'(in_ready), 64'd1);
    a = 8'h21; b = 8'h10; c_in = 1'b0; in_valid = 1'b1;
    step();
    chk("iv_first_busy", 64'(busy), 64'd1);
    a = 8'h55; b = 8'hAA;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("iv_first_latency", 64'(lat), 64'd8);
    chk("iv_first_sum", 64'(sum), 64'h31);
    chk("iv_first_c_out", 64'(c_out), 64'd0);
    step();
    chk("iv_idle_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("iv_second_busy", 64'(busy), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("iv_second_latency", 64'(lat), 64'd8);
    chk("iv_second_sum", 64'(sum), 64'hFF);
    chk("iv_second_c_out", 64'(c_out), 64'd0);
    step();

    // Reset mid-RUN at count=3
    a = 8'h3C; b = 8'h0F; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_c_out", 64'(c_out), 64'd0);
    step();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) lat++;
    end
    chk("abort_no_out_valid", 64'(lat), 64'd0);
    do_op("post", 8'h01, 8'h01, 1'b0, 1'b0, lat);
    chk("post_latency", 64'(lat), 64'd8);
    chk("post_sum", 64'(sum), 64'h02);
    chk("post_c_out", 64'(c_out), 64'd0);
    step();

`ifdef SERIAL_ADDER_SUB_EN
    // 0x10 - 0x01 = 0x0F, no borrow
    do_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, lat);
    chk("sub1_sum", 64'(sum), 64'h0F);
    chk("sub1_c_out", 64'(c_out), 64'd1);
    step();
    // 0x01 - 0x02 = 0xFF, borrow
    do_op("sub2", 8'h01, 8'h02, 1'b0, 1'b1, lat);
    chk("sub2_sum", 64'(sum), 64'hFF);
    chk("sub2_c_out", 64'(c_out), 64'd0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
